// File: rtl/sample_feeder.sv
// Sample buffer that replays stored {x1,x2,t} samples to a neuron in epochs.
// Define SAMPLE_FEEDER_EPOCH_LIMIT_EN to abort a run after MAX_EPOCHS epochs.
module sample_feeder #(
  parameter int DEPTH      = 64,
  parameter int MAX_EPOCHS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [6:0]  wr_x1,
  input  logic [6:0]  wr_x2,
  input  logic [1:0]  wr_t,
  input  logic        clr,
  input  logic        go,
  input  logic        done,
  output logic [6:0]  X1Bus,
  output logic [6:0]  X2Bus,
  output logic [1:0]  tBus,
  output logic [31:0] nBus,
  output logic        start,
  output logic        busy,
  output logic        finished,
  output logic        full,
  output logic [15:0] epochs,
  output logic        timeout
);

  localparam int AW = $clog2(DEPTH);
`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif
  localparam logic [15:0] MAX_E = 16'(MAX_EPOCHS);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} state_t;

  state_t      state, state_nx;
  logic [AW:0] fill;
  logic [AW-1:0] rd_ptr;
  logic        load_cnt;
  logic        tout;
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_word;
  logic        last, ep_sat, limit_hit;
  logic [15:0] ep_inc;
  logic        do_wr, do_clr, do_go, do_adv, do_wrap, do_abort;

  assign rd_word   = mem[rd_ptr];
  assign full      = (fill == (AW+1)'(DEPTH));
  assign last      = ({1'b0, rd_ptr} == fill - 1'b1);
  assign ep_sat    = (epochs == 16'hFFFF);
  assign ep_inc    = ep_sat ? epochs : epochs + 16'd1;
  assign limit_hit = LIMIT_EN && !ep_sat && (ep_inc == MAX_E);
  assign timeout   = LIMIT_EN & tout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_wr    = 1'b0;
    do_clr   = 1'b0;
    do_go    = 1'b0;
    do_adv   = 1'b0;
    do_wrap  = 1'b0;
    do_abort = 1'b0;
    start    = 1'b0;
    busy     = 1'b1;
    nBus     = '0;
    X1Bus    = '0;
    X2Bus    = '0;
    tBus     = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        // go beats clr and wr_en; an ignored go lets them through
        if (go && fill != '0) begin
          do_go    = 1'b1;
          state_nx = LOAD;
        end else if (clr) begin
          do_clr = 1'b1;
        end else if (wr_en && !full) begin
          do_wr = 1'b1;
        end
      end
      LOAD: begin
        start = 1'b1;
        nBus  = {{(31-AW){1'b0}}, fill};
        if (load_cnt) state_nx = STREAM;
      end
      STREAM: begin
        nBus  = {{(31-AW){1'b0}}, fill};
        {X1Bus, X2Bus, tBus} = rd_word;
        if (done) begin
          state_nx = FIN;
        end else begin
          do_adv = 1'b1;
          if (last) begin
            do_wrap = 1'b1;
            if (limit_hit) begin
              do_abort = 1'b1;
              state_nx = FIN;
            end
          end
        end
      end
      FIN: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      rd_ptr   <= '0;
      load_cnt <= 1'b0;
      epochs   <= '0;
      finished <= 1'b0;
      tout     <= 1'b0;
    end else begin
      if (do_clr) fill <= '0;
      if (do_wr)  fill <= fill + 1'b1;
      if (do_go) begin
        rd_ptr   <= '0;
        load_cnt <= 1'b0;
        epochs   <= '0;
        finished <= 1'b0;
        tout     <= 1'b0;
      end
      if (state == LOAD) load_cnt <= 1'b1;
      if (do_adv) rd_ptr <= do_wrap ? '0 : rd_ptr + 1'b1;
      if (do_wrap) epochs <= ep_inc;
      if (do_abort) tout <= 1'b1;
      if (state == FIN) finished <= 1'b1;
    end
  end

  // sample RAM keeps its contents through reset and clr
  always_ff @(posedge clk) begin
    if (do_wr) mem[fill[AW-1:0]] <= {wr_x1, wr_x2, wr_t};
  end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 64, sample buffer entries (power of two).
REQ-002 Parameter MAX_EPOCHS, default 1024, epoch limit used only when SAMPLE_FEEDER_EPOCH_LIMIT_EN is defined.
REQ-003 Single clock clk, rising-edge; reset is asynchronous and active-low, port rst_n.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 wr_en  in  1  append one sample to buffer.
REQ-007 wr_x1  in  7  sample input X1, two's complement.
REQ-008 wr_x2  in  7  sample input X2, two's complement.
REQ-009 wr_t  in  2  target, 2'b01 = +1, 2'b11 = -1.
REQ-010 clr  in  1  empty the buffer.
REQ-011 go  in  1  begin a training run.
REQ-012 done  in  1  training-complete flag from the neuron module.
REQ-013 X1Bus  out  7  sample X1 to neuron.
REQ-014 X2Bus  out  7  sample X2 to neuron.
REQ-015 tBus  out  2  target to neuron.
REQ-016 nBus  out  32  sample count per epoch, zero-extended fill level.
REQ-017 start  out  1  neuron start strobe.
REQ-018 busy  out  1  run in progress.
REQ-019 finished  out  1  sticky run-complete flag.
REQ-020 full  out  1  buffer holds DEPTH samples.
REQ-021 epochs  out  16  completed epoch count.
REQ-022 timeout  out  1  sticky epoch-limit abort flag.

Function
REQ-023 Buffer stores {x1,x2,t}; write pointer = fill level; wr_en in IDLE with full=0 writes at fill, fill+1 next cycle.
REQ-024 wr_en when full=1 or busy=1 SHALL be ignored; clr in IDLE sets fill=0 next cycle; clr while busy ignored.
REQ-025 clr and wr_en in the same IDLE cycle: clr wins, no write.
REQ-026 States IDLE, LOAD, STREAM, FIN; go in IDLE with fill>=1 -> LOAD; go with fill=0 or go while busy ignored.
REQ-027 go and wr_en in the same IDLE cycle: go wins, write dropped; go clears finished, timeout, epochs.
REQ-028 LOAD lasts exactly 2 cycles: start=1, nBus=fill, sample buses=0; done ignored in LOAD; then -> STREAM.
REQ-029 STREAM: each cycle presents entry rd_ptr on X1Bus/X2Bus/tBus, starting at entry 0; first sample on the cycle after LOAD ends.
REQ-030 rd_ptr wraps from fill-1 to 0; each wrap increments epochs, saturating at 16'hFFFF.
REQ-031 nBus holds fill throughout LOAD and STREAM; start=0 in STREAM.
REQ-032 done sampled 1 in STREAM -> FIN next cycle; buses driven 0 in FIN.
REQ-033 FIN lasts 1 cycle, sets finished=1, then IDLE; busy=1 in LOAD, STREAM, FIN only.
REQ-034 Buffer contents persist across runs; a new go replays the same samples.

Reset
REQ-035 rst_n=0 immediately forces IDLE, fill=0, rd_ptr=0; all outputs 0: buses, nBus, start, busy, finished, full, epochs, timeout.
REQ-036 Reset mid-run aborts with no FIN; buffer RAM is not cleared.

Configuration
REQ-037 SAMPLE_FEEDER_EPOCH_LIMIT_EN defined: at the wrap where epochs reaches MAX_EPOCHS, go to FIN with timeout=1, finished=1.
REQ-038 Macro undefined: streaming continues until done; timeout tied 0.

Verification
REQ-039 Write 3 samples, go -> start=1 for 2 cycles, nBus=3, then entries 0,1,2,0,1... with epochs incrementing on each wrap.
REQ-040 Write 64 samples -> full=1; 65th wr_en ignored; go -> nBus=64.
REQ-041 done=1 on 5th STREAM cycle with fill=2 -> FIN next cycle, finished=1, epochs=2, busy=0 after FIN.
REQ-042 go with fill=0 -> no state change, start stays 0; go during STREAM ignored.
REQ-043 rst_n=0 mid-STREAM -> all outputs 0 immediately; after release, go with fill=0 ignored.
REQ-044 Macro defined, MAX_EPOCHS=4, fill=2, done held 0 -> abort after 8 STREAM cycles, timeout=1, epochs=4.
